matrix_scan_driver: RTL and testbench

//  Parametrised successor to the fixed 8x8 row-scan LED driver: scans a ROWS x COLS matrix
//  row by row from a double-buffered frame store. Blanks between rows to stop ghosting and

---
 rtl/matrix_scan_driver_if.sv | 34 +++
 rtl/matrix_scan_driver.sv | 157 +++++++++++++++
 tb/tb_matrix_scan_driver.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/matrix_scan_driver_if.sv
// Frame-store / scan-output bus between the game logic (master) and matrix_scan_driver (slave).
// With BRIGHTNESS_EN defined the bus also carries the 4-bit global brightness input.
interface matrix_scan_driver_if #(
    parameter int ROWS = 8,
    parameter int COLS = 8
);
    // One spare bit so that row numbers >= ROWS can be presented and rejected.
    localparam int WR_W = $clog2(ROWS) + 1;

    // Single-cycle strobes, no backpressure: wr_en and swap_req are sampled on every
    // rising clk edge; swap_ack and frame_start are one-cycle pulses with no ready.
    logic            wr_en;
    logic [WR_W-1:0] wr_row;
    logic [COLS-1:0] wr_data;
    logic            swap_req;
    logic            swap_ack;
    logic            frame_start;
    logic [ROWS-1:0] row;
    logic [COLS-1:0] col;
    logic            dbg_state;
`ifdef BRIGHTNESS_EN
    logic [3:0]      brightness;

    modport master (output wr_en, wr_row, wr_data, swap_req, brightness,
                    input  swap_ack, frame_start, row, col, dbg_state);
    modport slave  (input  wr_en, wr_row, wr_data, swap_req, brightness,
                    output swap_ack, frame_start, row, col, dbg_state);
`else
    modport master (output wr_en, wr_row, wr_data, swap_req,
                    input  swap_ack, frame_start, row, col, dbg_state);
    modport slave  (input  wr_en, wr_row, wr_data, swap_req,
                    output swap_ack, frame_start, row, col, dbg_state);
`endif
endinterface

// File: rtl/matrix_scan_driver.sv
// Row-scanned ROWS x COLS LED matrix driver with double-buffered, tear-free frame store.
// Optional feature macro BRIGHTNESS_EN: frame-latched global PWM brightness on the columns.
module matrix_scan_driver #(
    parameter int ROWS         = 8,
    parameter int COLS         = 8,
    parameter int CLK_HZ       = 27000000,
    parameter int REFRESH_HZ   = 400,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    matrix_scan_driver_if.slave io_bus
);
    localparam int DWELL = CLK_HZ / (ROWS * REFRESH_HZ);
    localparam int RI_W  = $clog2(ROWS);
    localparam int DC_W  = ($clog2(DWELL) > 4) ? $clog2(DWELL) : 4;
    localparam int WR_W  = $clog2(ROWS) + 1;

    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_ON    = 1'b1;

    generate
        if (ROWS < 2) begin : g_bad_rows
            $error("matrix_scan_driver: ROWS (%0d) must be at least 2", ROWS);
        end
        if (DWELL <= BLANK_CYCLES) begin : g_bad_dwell
            $error("matrix_scan_driver: DWELL (%0d) must exceed BLANK_CYCLES (%0d)", DWELL, BLANK_CYCLES);
        end
    endgenerate

    logic [RI_W-1:0] r_row_idx;
    logic [DC_W-1:0] r_dwell_cnt;
    logic [COLS-1:0] r_buf_a [ROWS];
    logic [COLS-1:0] r_buf_b [ROWS];
    logic            r_disp_sel;      // 0: buffer A is on display, 1: buffer B
    logic            r_pending;
    logic            r_swap_flag;
    logic [ROWS-1:0] r_row;
    logic [COLS-1:0] r_col;
    logic            r_frame_start;
    logic            r_swap_ack;
    logic [0:0]      r_state;

    logic            w_last_dwell;
    logic            w_last_row;
    logic            w_frame_first;
    logic            w_swap;
    logic            w_wr_ok;
    logic [RI_W-1:0] w_wr_idx;
    logic [0:0]      w_state;
    logic [COLS-1:0] w_disp_row;
    logic            w_col_en;

    assign w_last_dwell  = (r_dwell_cnt == DC_W'(DWELL - 1));
    assign w_last_row    = (r_row_idx == RI_W'(ROWS - 1));
    assign w_frame_first = (r_row_idx == '0) && (r_dwell_cnt == '0);
    assign w_swap        = w_last_row && w_last_dwell && (r_pending || io_bus.swap_req);
    assign w_wr_ok       = io_bus.wr_en && (io_bus.wr_row < WR_W'(ROWS));
    assign w_wr_idx      = io_bus.wr_row[RI_W-1:0];
    assign w_state       = (r_dwell_cnt < DC_W'(BLANK_CYCLES)) ? ST_BLANK : ST_ON;

    always_comb begin
        w_disp_row = r_buf_a[r_row_idx];
        if (r_disp_sel) begin
            w_disp_row = r_buf_b[r_row_idx];
        end
    end

`ifdef BRIGHTNESS_EN
    logic [3:0] r_bright_q;

    // Latched only at the frame's first cycle so a mid-frame change never splits a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bright_q <= 4'd0;
        end else if (w_frame_first) begin
            r_bright_q <= io_bus.brightness;
        end
    end

    assign w_col_en = (r_dwell_cnt[3:0] < r_bright_q);
`else
    assign w_col_en = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dwell_cnt <= '0;
            r_row_idx   <= '0;
        end else if (w_last_dwell) begin
            r_dwell_cnt <= '0;
            r_row_idx   <= w_last_row ? '0 : r_row_idx + RI_W'(1);
        end else begin
            r_dwell_cnt <= r_dwell_cnt + DC_W'(1);
        end
    end

    // Writes target whichever buffer is not on display at this edge; in the swap
    // cycle that is the outgoing back buffer, which becomes the new display.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ROWS; i++) begin
                r_buf_a[i] <= '0;
                r_buf_b[i] <= '0;
            end
        end else if (w_wr_ok) begin
            if (r_disp_sel) begin
                r_buf_a[w_wr_idx] <= io_bus.wr_data;
            end else begin
                r_buf_b[w_wr_idx] <= io_bus.wr_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_disp_sel  <= 1'b0;
            r_pending   <= 1'b0;
            r_swap_flag <= 1'b0;
        end else begin
            r_swap_flag <= w_swap;
            if (w_swap) begin
                r_disp_sel <= ~r_disp_sel;
                r_pending  <= 1'b0;
            end else if (io_bus.swap_req) begin
                r_pending  <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row         <= '0;
            r_col         <= '0;
            r_frame_start <= 1'b0;
            r_swap_ack    <= 1'b0;
            r_state       <= ST_BLANK;
        end else begin
            r_state       <= w_state;
            r_frame_start <= w_frame_first;
            r_swap_ack    <= w_frame_first && r_swap_flag;
            if (w_state == ST_ON) begin
                r_row <= {{(ROWS-1){1'b0}}, 1'b1} << r_row_idx;
                r_col <= w_col_en ? w_disp_row : '0;
            end else begin
                r_row <= '0;
                r_col <= '0;
            end
        end
    end

    assign io_bus.row         = r_row;
    assign io_bus.col         = r_col;
    assign io_bus.frame_start = r_frame_start;
    assign io_bus.swap_ack    = r_swap_ack;
    assign io_bus.dbg_state   = r_state;
endmodule

// File: tb/tb_matrix_scan_driver.sv
// Self-checking bench for matrix_scan_driver: 8x8 matrix, DWELL=8, 64-cycle frames.
module tb_matrix_scan_driver;
    localparam int ROWS = 8, COLS = 8, CLK_HZ = 640, REFRESH_HZ = 10, BLANK_CYCLES = 2;
    localparam int DWELL = 8, FRAME = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [7:0] exp_q[$];

    matrix_scan_driver_if #(.ROWS(ROWS), .COLS(COLS)) bus();

    matrix_scan_driver #(
        .ROWS(ROWS), .COLS(COLS), .CLK_HZ(CLK_HZ),
        .REFRESH_HZ(REFRESH_HZ), .BLANK_CYCLES(BLANK_CYCLES)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .io_bus(bus)
    );

    always #5 clk = ~clk;

    // Reference model: frame position 0..63, display/back contents as plain arrays that
    // trade places on a swap; exp_* are the outputs expected after each rising edge.
    int         m_pos, m_r, m_d;
    bit         m_pend, m_swapped, m_swap_now, m_lit;
    logic [3:0] m_bright;
    logic [7:0] m_disp[ROWS], m_back[ROWS], m_tmp;
    logic [7:0] exp_row, exp_col;
    logic       exp_fs, exp_ack;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pos = 0; m_pend = 0; m_swapped = 0; m_bright = 4'd0;
            for (int i = 0; i < ROWS; i++) begin
                m_disp[i] = 8'h00;
                m_back[i] = 8'h00;
            end
            exp_row = 8'h00; exp_col = 8'h00; exp_fs = 1'b0; exp_ack = 1'b0;
        end else begin
            m_r = m_pos / DWELL;
            m_d = m_pos % DWELL;
            exp_fs  = (m_pos == 0);
            exp_ack = exp_fs && m_swapped;
`ifdef BRIGHTNESS_EN
            if (m_pos == 0) m_bright = bus.brightness;
            m_lit = ((m_d % 16) < int'(m_bright));
`else
            m_lit = 1'b1;
`endif
            if (m_d < BLANK_CYCLES) begin
                exp_row = 8'h00;
                exp_col = 8'h00;
            end else begin
                exp_row = 8'(1 << m_r);
                exp_col = m_lit ? m_disp[m_r] : 8'h00;
            end
            if (bus.wr_en && bus.wr_row < 4'(ROWS)) m_back[bus.wr_row[2:0]] = bus.wr_data;
            m_swap_now = (m_pos == FRAME - 1) && (m_pend || bus.swap_req);
            m_pend = !m_swap_now && (m_pend || bus.swap_req);
            if (m_swap_now) begin
                for (int i = 0; i < ROWS; i++) begin
                    m_tmp = m_disp[i]; m_disp[i] = m_back[i]; m_back[i] = m_tmp;
                end
            end
            m_swapped = m_swap_now;
            m_pos = (m_pos + 1) % FRAME;
        end
    end

    task automatic clear_inputs();
        bus.wr_en = 1'b0; bus.wr_row = 4'd0; bus.wr_data = 8'h00; bus.swap_req = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [17:0] obs;
        clear_inputs();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        obs = {bus.row, bus.col, bus.frame_start, bus.swap_ack};
        checks++;
        if (obs !== 18'h0) begin
            errors++; $display("FAIL reset_outputs: got %h expected 00000", obs);
        end
        checks++;
        if (bus.dbg_state !== 1'b0) begin
            errors++; $display("FAIL reset_state: got %b expected 0", bus.dbg_state);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_scan_empty();
        logic [17:0] obs, expv;
        logic [7:0]  want;
        exp_q = {8'h00, 8'h00, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h00, 8'h00, 8'h02};
        for (int k = 0; k < 2 * FRAME + 2; k++) begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                want = exp_q.pop_front();
                checks++;
                if (bus.row !== want) begin
                    errors++; $display("FAIL scan_row_seq: k=%0d got %h expected %h", k, bus.row, want);
                end
            end
            checks++;
            if (bus.col !== 8'h00 || bus.frame_start !== (k % FRAME == 0)) begin
                errors++; $display("FAIL scan_empty: k=%0d got col=%h fs=%b expected col=00 fs=%b",
                                   k, bus.col, bus.frame_start, (k % FRAME == 0));
            end
            obs = {bus.row, bus.col, bus.frame_start, bus.swap_ack};
            expv = {exp_row, exp_col, exp_fs, exp_ack};
            checks++;
            if (obs !== expv) begin
                errors++; $display("FAIL scan_empty_model: k=%0d got %h expected %h", k, obs, expv);
            end
        end
    endtask

    task automatic test_write_swap();
        logic [17:0] obs, expv;
        int wk, sk, lit_n, first_lit, ack_n, ack_k;
        do_reset();
        wk = $urandom_range(0, 20);
        sk = $urandom_range(wk, 40);
        lit_n = 0; first_lit = -1; ack_n = 0; ack_k = -1;
        for (int k = 0; k < 3 * FRAME; k++) begin
            @(negedge clk);
            obs = {bus.row, bus.col, bus.frame_start, bus.swap_ack};
            expv = {exp_row, exp_col, exp_fs, exp_ack};
            checks++;
            if (obs !== expv) begin
                errors++; $display("FAIL write_swap_model: k=%0d got %h expected %h", k, obs, expv);
            end
            if (bus.col !== 8'h00) begin
                lit_n++;
                if (first_lit < 0) first_lit = k;
                checks++;
                if ({bus.row, bus.col} !== 16'h08A5) begin
                    errors++; $display("FAIL write_swap_lit: k=%0d got row=%h col=%h expected row=08 col=a5",
                                       k, bus.row, bus.col);
                end
            end
            if (bus.swap_ack === 1'b1) begin ack_n++; ack_k = k; end
            bus.wr_en = (k == wk); bus.wr_row = 4'd3; bus.wr_data = 8'hA5;
            bus.swap_req = (k == sk);
        end
        clear_inputs();
        checks++;
        if (lit_n != 12 || first_lit != 90) begin
            errors++; $display("FAIL write_swap_shown: got %0d lit from k=%0d expected 12 lit from k=90", lit_n, first_lit);
        end
        checks++;
        if (ack_n != 1 || ack_k != FRAME) begin
            errors++; $display("FAIL write_swap_ack: got %0d acks last k=%0d expected 1 at k=64", ack_n, ack_k);
        end
    endtask

    task automatic test_swap_boundary();
        logic [17:0] obs, expv;
        int ack_ks[$];
        do_reset();
        for (int k = 0; k < 3 * FRAME + 8; k++) begin
            @(negedge clk);
            obs = {bus.row, bus.col, bus.frame_start, bus.swap_ack};
            expv = {exp_row, exp_col, exp_fs, exp_ack};
            checks++;
            if (obs !== expv) begin
                errors++; $display("FAIL boundary_model: k=%0d got %h expected %h", k, obs, expv);
            end
            if (bus.swap_ack === 1'b1) ack_ks.push_back(k);
            bus.wr_en = (k < ROWS); bus.wr_row = 4'(k); bus.wr_data = 8'($urandom_range(1, 255));
            bus.swap_req = (k == FRAME - 2) || (k == FRAME - 1);
        end
        clear_inputs();
        checks++;
        if (ack_ks.size() != 2) begin
            errors++; $display("FAIL boundary_ack_count: got %0d expected 2", ack_ks.size());
        end else begin
            checks++;
            if (ack_ks[0] != FRAME || ack_ks[1] != 2 * FRAME) begin
                errors++; $display("FAIL boundary_ack_time: got k=%0d,%0d expected k=64,128", ack_ks[0], ack_ks[1]);
            end
        end
    endtask

    task automatic test_multi_swap();
        logic [17:0] obs, expv;
        int a, b, c, ack_n, lit1, lit2;
        do_reset();
        a = $urandom_range(1, 20); b = $urandom_range(21, 40); c = $urandom_range(41, 60);
        ack_n = 0; lit1 = 0; lit2 = 0;
        for (int k = 0; k < 3 * FRAME; k++) begin
            @(negedge clk);
            obs = {bus.row, bus.col, bus.frame_start, bus.swap_ack};
            expv = {exp_row, exp_col, exp_fs, exp_ack};
            checks++;
            if (obs !== expv) begin
                errors++; $display("FAIL multi_swap_model: k=%0d got %h expected %h", k, obs, expv);
            end
            if (bus.swap_ack === 1'b1) ack_n++;
            if (bus.col !== 8'h00 && k >= FRAME && k < 2 * FRAME) lit1++;
            if (bus.col !== 8'h00 && k >= 2 * FRAME) lit2++;
            bus.wr_en = (k < ROWS); bus.wr_row = 4'(k); bus.wr_data = 8'($urandom_range(1, 255));
            bus.swap_req = (k == a) || (k == b) || (k == c);
        end
        clear_inputs();
        checks++;
        if (ack_n != 1) begin
            errors++; $display("FAIL multi_swap_acks: got %0d expected 1", ack_n);
        end
        checks++;
        if (lit1 != 48 || lit2 != 48) begin
            errors++; $display("FAIL multi_swap_toggle: got lit %0d/%0d expected 48/48", lit1, lit2);
        end
    endtask

    task automatic test_bad_row();
        logic [17:0] obs, expv;
        int lit_n, ack_n;
        do_reset();
        lit_n = 0; ack_n = 0;
        for (int k = 0; k < 2 * FRAME + 8; k++) begin
            @(negedge clk);
            obs = {bus.row, bus.col, bus.frame_start, bus.swap_ack};
            expv = {exp_row, exp_col, exp_fs, exp_ack};
            checks++;
            if (obs !== expv) begin
                errors++; $display("FAIL bad_row_model: k=%0d got %h expected %h", k, obs, expv);
            end
            if (bus.col !== 8'h00) lit_n++;
            if (bus.swap_ack === 1'b1) ack_n++;
            bus.wr_en = (k < 8); bus.wr_row = (k == 0) ? 4'd9 : 4'(8 + k); bus.wr_data = 8'hFF;
            bus.swap_req = (k == 10);
        end
        clear_inputs();
        checks++;
        if (lit_n != 0 || ack_n != 1) begin
            errors++; $display("FAIL bad_row_ignored: got lit=%0d acks=%0d expected lit=0 acks=1", lit_n, ack_n);
        end
    endtask

    task automatic test_reset_midframe();
        logic [17:0] obs, expv;
        logic [7:0]  v1, v2;
        v1 = 8'($urandom_range(1, 255));
        v2 = 8'($urandom_range(1, 255));
        do_reset();
        for (int k = 0; k < FRAME + 44; k++) begin
            @(negedge clk);
            obs = {bus.row, bus.col, bus.frame_start, bus.swap_ack};
            expv = {exp_row, exp_col, exp_fs, exp_ack};
            checks++;
            if (obs !== expv) begin
                errors++; $display("FAIL midreset_pre_model: k=%0d got %h expected %h", k, obs, expv);
            end
            bus.wr_en = (k == 0) || (k == 80); bus.wr_row = 4'd5;
            bus.wr_data = (k == 0) ? v1 : v2;
            bus.swap_req = (k == 0) || (k == 80);
        end
        clear_inputs();
        checks++;
        if (bus.row !== 8'h20 || bus.col !== v1) begin
            errors++; $display("FAIL midreset_lit: got row=%h col=%h expected row=20 col=%h", bus.row, bus.col, v1);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.row, bus.col, bus.frame_start, bus.swap_ack} !== 18'h0) begin
            errors++; $display("FAIL midreset_async_dark: got row=%h col=%h expected row=00 col=00", bus.row, bus.col);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 2 * FRAME + 2; k++) begin
            @(negedge clk);
            obs = {bus.row, bus.col, bus.frame_start, bus.swap_ack};
            expv = {exp_row, exp_col, exp_fs, exp_ack};
            checks++;
            if (obs !== expv) begin
                errors++; $display("FAIL midreset_post_model: k=%0d got %h expected %h", k, obs, expv);
            end
            checks++;
            if (bus.col !== 8'h00 || bus.swap_ack !== 1'b0 || bus.frame_start !== (k % FRAME == 0) ||
                (k < 2 && bus.row !== 8'h00) || (k == 2 && bus.row !== 8'h01)) begin
                errors++; $display("FAIL midreset_restart: k=%0d got row=%h col=%h fs=%b ack=%b", k,
                                   bus.row, bus.col, bus.frame_start, bus.swap_ack);
            end
        end
    endtask

`ifdef BRIGHTNESS_EN
    task automatic test_brightness();
        logic [17:0] obs, expv;
        logic [7:0]  want;
        int d;
        bus.brightness = 4'd5;
        do_reset();
        for (int k = 0; k < 3 * FRAME; k++) begin
            @(negedge clk);
            obs = {bus.row, bus.col, bus.frame_start, bus.swap_ack};
            expv = {exp_row, exp_col, exp_fs, exp_ack};
            checks++;
            if (obs !== expv) begin
                errors++; $display("FAIL bright_model: k=%0d got %h expected %h", k, obs, expv);
            end
            d = k % DWELL;
            if (k >= FRAME) begin
                if (k < 2 * FRAME) want = (d >= 2 && d <= 4) ? 8'hFF : 8'h00;
                else               want = (d >= 2) ? 8'hFF : 8'h00;
                checks++;
                if (bus.col !== want) begin
                    errors++; $display("FAIL bright_duty: k=%0d got col=%h expected %h", k, bus.col, want);
                end
            end
            bus.wr_en = (k < ROWS); bus.wr_row = 4'(k); bus.wr_data = 8'hFF;
            bus.swap_req = (k == 1);
            if (k == FRAME + 20) bus.brightness = 4'd9;
        end
        clear_inputs();
        bus.brightness = 4'd15;
    endtask
`endif

    initial begin
        clear_inputs();
`ifdef BRIGHTNESS_EN
        bus.brightness = 4'd15;
`endif
        test_reset();
        test_scan_empty();
        test_write_swap();
        test_swap_boundary();
        test_multi_swap();
        test_bad_row();
        test_reset_midframe();
`ifdef BRIGHTNESS_EN
        test_brightness();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
